rf_wb_arbiter: RTL and testbench

- Sequences the register file's single write port between two writeback sources:
  - requester 0: EXU, single-cycle ALU results.
  - requester 1: LSU, load data of variable latency.
- Arbitrates round-robin and registers the winning write into the register file's wen/rd/result inputs.
- Keeps a 32-entry scoreboard of destination registers with an outstanding long-latency write, so issue logic can stall on read-after-write hazards.

---
 rtl/rf_wb_arbiter.sv | 92 +++++++++
 tb/tb_rf_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter feeding the register file write port, with a
// per-register scoreboard of outstanding long-latency writes for hazard checks.
module rf_wb_arbiter #(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [4:0]    req0_rd,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [4:0]    req1_rd,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          sb_set,
    input  logic [4:0]    sb_set_rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          rf_wen,
    output logic [4:0]    rf_rd,
    output logic [DW-1:0] rf_result
);

    logic            rr_ptr;
    logic            grant0;
    logic            grant1;
    logic [4:0]      win_rd;
    logic [DW-1:0]   win_data;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;

    always_comb begin
        grant0   = req0_valid && (!req1_valid || !rr_ptr);
        grant1   = req1_valid && (!req0_valid || rr_ptr);
        win_rd   = grant1 ? req1_rd : req0_rd;
        win_data = grant1 ? req1_data : req0_data;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Pointer only moves on contention, handing priority to the loser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (req0_valid && req1_valid) begin
            rr_ptr <= grant0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen    <= 1'b0;
            rf_rd     <= '0;
            rf_result <= '0;
        end else if (grant0 || grant1) begin
            rf_wen    <= (win_rd != 5'd0);
            rf_rd     <= win_rd;
            rf_result <= win_data;
        end else begin
            rf_wen    <= 1'b0;
        end
    end

    // Set is applied after clear so a fresh issue to the committing rd stays busy.
    always_comb begin
        sb_next = sb;
        if (rf_wen) begin
            sb_next[rf_rd] = 1'b0;
        end
        if (sb_set && (sb_set_rd != 5'd0)) begin
            sb_next[sb_set_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    assign rs1_busy = sb[rs1];
    assign rs2_busy = sb[rs2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, randomized run against a
// behavioural model, and an asynchronous mid-cycle reset sequence.
module tb_rf_wb_arbiter;

    typedef struct {
        bit          v0;
        logic [4:0]  rd0;
        logic [31:0] d0;
        bit          v1;
        logic [4:0]  rd1;
        logic [31:0] d1;
        bit          set;
        logic [4:0]  setrd;
        logic [4:0]  q1;
        logic [4:0]  q2;
        bit          er0;
        bit          er1;
        bit          ewen;
        logic [4:0]  erd;
        logic [31:0] eres;
        bit          eb1;
        bit          eb2;
        bit          chk;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_rd = '0;
    logic [31:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_rd = '0;
    logic [31:0] req1_data = '0;
    logic        req1_ready;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_set_rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_result;

    int total = 0;
    int bad = 0;

    // Reference state: priority holder, pending write, busy set.
    int          mPtr;
    bit          mWen;
    int          mRd;
    logic [31:0] mRes;
    bit          mKnown;
    bit          mBusy[32];
    int          mLastG;

    vec_t tbl[24];

    rf_wb_arbiter #(.DW(32), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .sb_set(sb_set), .sb_set_rd(sb_set_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_result(rf_result)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit v0, int rd0, int d0, bit v1, int rd1, int d1,
                                bit set, int setrd, int q1, int q2, bit er0, bit er1,
                                bit ewen, int erd, int eres, bit eb1, bit eb2, bit chk);
        vec_t v;
        v.v0 = v0; v.rd0 = 5'(rd0); v.d0 = 32'(d0);
        v.v1 = v1; v.rd1 = 5'(rd1); v.d1 = 32'(d1);
        v.set = set; v.setrd = 5'(setrd); v.q1 = 5'(q1); v.q2 = 5'(q2);
        v.er0 = er0; v.er1 = er1; v.ewen = ewen; v.erd = 5'(erd); v.eres = 32'(eres);
        v.eb1 = eb1; v.eb2 = eb2; v.chk = chk;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req0_valid = v.v0; req0_rd = v.rd0; req0_data = v.d0;
        req1_valid = v.v1; req1_rd = v.rd1; req1_data = v.d1;
        sb_set = v.set; sb_set_rd = v.setrd; rs1 = v.q1; rs2 = v.q2;
    endtask

    task automatic modelReset();
        mPtr = 0; mWen = 0; mRd = 0; mRes = '0; mKnown = 1; mLastG = -1;
        for (int i = 0; i < 32; i++) mBusy[i] = 0;
    endtask

    // One clock: check at the falling edge, advance the model, land #1 after the rising edge.
    task automatic runCycle(input bit useTbl, input vec_t v, input string tag);
        int g;
        bit nb[32];
        @(negedge clk);
        if (req0_valid && req1_valid) g = mPtr;
        else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
        else g = -1;
        checkOutput({tag, "_ready0"}, 32'(req0_ready), 32'(g == 0));
        checkOutput({tag, "_ready1"}, 32'(req1_ready), 32'(g == 1));
        checkOutput({tag, "_wen"}, 32'(rf_wen), 32'(mWen));
        if (mKnown) begin
            checkOutput({tag, "_rd"}, 32'(rf_rd), 32'(mRd));
            checkOutput({tag, "_result"}, rf_result, mRes);
        end
        checkOutput({tag, "_busy1"}, 32'(rs1_busy), 32'(rs1 != 0 && mBusy[rs1]));
        checkOutput({tag, "_busy2"}, 32'(rs2_busy), 32'(rs2 != 0 && mBusy[rs2]));
        if (useTbl) begin
            checkOutput({tag, "_tbl_ready0"}, 32'(req0_ready), 32'(v.er0));
            checkOutput({tag, "_tbl_ready1"}, 32'(req1_ready), 32'(v.er1));
            checkOutput({tag, "_tbl_wen"}, 32'(rf_wen), 32'(v.ewen));
            checkOutput({tag, "_tbl_busy1"}, 32'(rs1_busy), 32'(v.eb1));
            checkOutput({tag, "_tbl_busy2"}, 32'(rs2_busy), 32'(v.eb2));
            if (v.chk) begin
                checkOutput({tag, "_tbl_rd"}, 32'(rf_rd), 32'(v.erd));
                checkOutput({tag, "_tbl_result"}, rf_result, v.eres);
            end
        end
        for (int i = 0; i < 32; i++) begin
            nb[i] = mBusy[i];
            if (mWen && mRd == i) nb[i] = 0;
            if (sb_set && sb_set_rd == 5'(i) && i != 0) nb[i] = 1;
        end
        for (int i = 0; i < 32; i++) mBusy[i] = nb[i];
        if (g >= 0) begin
            int rd;
            rd = (g == 0) ? int'(req0_rd) : int'(req1_rd);
            mWen = (rd != 0);
            if (rd != 0) begin
                mRd = rd;
                mRes = (g == 0) ? req0_data : req1_data;
                mKnown = 1;
            end else begin
                mKnown = 0;
            end
        end else begin
            mWen = 0;
        end
        if (req0_valid && req1_valid) mPtr = 1 - g;
        mLastG = g;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        bit h0v, h1v;
        logic [4:0] h0rd, h1rd;
        logic [31:0] h0d, h1d;

        tbl[0]  = mk(0,0,0,       0,0,0,       0,0, 0,0, 0,0, 0,0,0,       0,0,1);
        tbl[1]  = mk(1,5,'h1234,  0,0,0,       0,0, 0,0, 1,0, 0,0,0,       0,0,1);
        tbl[2]  = mk(0,0,0,       0,0,0,       0,0, 0,0, 0,0, 1,5,'h1234,  0,0,1);
        tbl[3]  = mk(0,0,0,       0,0,0,       0,0, 0,0, 0,0, 0,5,'h1234,  0,0,1);
        tbl[4]  = mk(1,1,'h101,   1,11,'hB0B,  0,0, 0,0, 1,0, 0,5,'h1234,  0,0,1);
        tbl[5]  = mk(1,2,'h102,   1,11,'hB0B,  0,0, 0,0, 0,1, 1,1,'h101,   0,0,1);
        tbl[6]  = mk(1,2,'h102,   0,0,0,       0,0, 0,0, 1,0, 1,11,'hB0B,  0,0,1);
        tbl[7]  = mk(1,3,'h103,   0,0,0,       0,0, 0,0, 1,0, 1,2,'h102,   0,0,1);
        tbl[8]  = mk(0,0,0,       0,0,0,       0,0, 0,0, 0,0, 1,3,'h103,   0,0,1);
        tbl[9]  = mk(0,0,0,       0,0,0,       0,0, 0,0, 0,0, 0,3,'h103,   0,0,1);
        tbl[10] = mk(0,0,0,       0,0,0,       1,7, 7,0, 0,0, 0,3,'h103,   0,0,1);
        tbl[11] = mk(0,0,0,       1,7,'hAA,    0,0, 7,0, 0,1, 0,3,'h103,   1,0,1);
        tbl[12] = mk(0,0,0,       0,0,0,       0,0, 7,0, 0,0, 1,7,'hAA,    1,0,1);
        tbl[13] = mk(0,0,0,       0,0,0,       0,0, 7,0, 0,0, 0,7,'hAA,    0,0,1);
        tbl[14] = mk(1,9,'h99,    0,0,0,       0,0, 0,9, 1,0, 0,7,'hAA,    0,0,1);
        tbl[15] = mk(0,0,0,       0,0,0,       1,9, 0,9, 0,0, 1,9,'h99,    0,0,1);
        tbl[16] = mk(0,0,0,       0,0,0,       0,0, 0,9, 0,0, 0,9,'h99,    0,1,1);
        tbl[17] = mk(0,0,0,       0,0,0,       1,0, 9,0, 0,0, 0,9,'h99,    1,0,1);
        tbl[18] = mk(0,0,0,       0,0,0,       0,0, 9,0, 0,0, 0,9,'h99,    1,0,1);
        tbl[19] = mk(1,0,'hFFFF,  0,0,0,       0,0, 9,0, 1,0, 0,9,'h99,    1,0,1);
        tbl[20] = mk(0,0,0,       0,0,0,       0,0, 9,0, 0,0, 0,0,0,       1,0,0);
        tbl[21] = mk(1,12,'hC0C,  1,13,'hD0D,  0,0, 3,0, 1,0, 0,0,0,       0,0,1);
        tbl[22] = mk(0,0,0,       1,13,'hD0D,  0,0, 3,0, 0,1, 1,12,'hC0C,  0,0,1);
        tbl[23] = mk(0,0,0,       0,0,0,       0,0, 3,0, 0,0, 1,13,'hD0D,  0,0,1);

        modelReset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i <= 20; i++) begin
            applyStimulus(tbl[i]);
            runCycle(1, tbl[i], $sformatf("row%0d", i));
        end

        h0v = 0; h1v = 0; h0rd = '0; h1rd = '0; h0d = '0; h1d = '0;
        for (int n = 0; n < 400; n++) begin
            if (!h0v || mLastG == 0) begin
                h0v = 1'($urandom_range(0, 1)); h0rd = 5'($urandom_range(0, 31)); h0d = $urandom;
            end
            if (!h1v || mLastG == 1) begin
                h1v = 1'($urandom_range(0, 1)); h1rd = 5'($urandom_range(0, 31)); h1d = $urandom;
            end
            v = mk(h0v, h0rd, h0d, h1v, h1rd, h1d, 1'($urandom_range(0, 3) == 0),
                   $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   0, 0, 0, 0, 0, 0, 0, 0);
            req0_valid = h0v; req0_rd = h0rd; req0_data = h0d;
            req1_valid = h1v; req1_rd = h1rd; req1_data = h1d;
            sb_set = v.set; sb_set_rd = v.setrd; rs1 = v.q1; rs2 = v.q2;
            runCycle(0, v, $sformatf("rnd%0d", n));
        end

        v = mk(0,0,0, 1,4,'h55, 1,3, 3,0, 0,0, 0,0,0, 0,0,0);
        applyStimulus(v);
        runCycle(0, v, "pre_rst");
        v = mk(0,0,0, 0,0,0, 0,0, 3,0, 0,0, 0,0,0, 0,0,0);
        applyStimulus(v);
        #1;
        checkOutput("rst_before_wen", 32'(rf_wen), 32'd1);
        checkOutput("rst_before_busy3", 32'(rs1_busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_wen", 32'(rf_wen), 32'd0);
        checkOutput("rst_async_rd", 32'(rf_rd), 32'd0);
        checkOutput("rst_async_result", rf_result, 32'd0);
        checkOutput("rst_async_busy3", 32'(rs1_busy), 32'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 21; i <= 23; i++) begin
            applyStimulus(tbl[i]);
            runCycle(1, tbl[i], $sformatf("row%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
